instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, ROM addressing and IF/ID pipeline register.
// Latency: one edge from pc == A to id_instr holding the word at A.
// Backpressure: stall freezes pc and IF/ID; flush invalidates IF/ID. The optional
// branch delay slot is enabled with the DELAY_SLOT_EN macro.
module instr_fetch #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 rom_sel,
    input  logic [31:0]          rom_dout,
    output logic                 id_valid,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc_plus4,
    output logic [31:0]          pc,
    output logic [31:0]          fetch_cnt
);

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        deliver;
    logic        unused_redirect_low;

    // Word-aligned fetch: ROM sees only the word index, higher bits alias.
    assign rom_addr        = pc[ADDR_BITS+1:2];
    assign rom_sel         = !stall && !rst;
    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // Byte offset of the redirect target is discarded by alignment.
    assign unused_redirect_low = &{1'b0, redirect_pc[1:0]};

`ifdef DELAY_SLOT_EN
    // Delay slot: the word fetched alongside a redirect still executes.
    assign deliver = !flush;
`else
    // No delay slot: the word fetched alongside a redirect is squashed.
    assign deliver = !flush && !redirect;
`endif

    // Program counter: reset, hold on stall, redirect, else advance by one word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            if (redirect) begin
                pc <= redirect_target;
            end else begin
                pc <= pc_plus4;
            end
        end
    end

    // IF/ID register: flush clears valid even under stall; squashed slots carry a NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_pc       <= 32'h0000_0000;
            id_instr    <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0000;
        end else if (stall) begin
            if (flush) begin
                id_valid <= 1'b0;
            end
        end else begin
            id_valid    <= deliver;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_instr    <= deliver ? rom_dout : 32'h0000_0000;
        end
    end

    // Delivered-instruction counter, bumps whenever a valid word enters IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'h0000_0000;
        end else if (!stall && deliver) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the fetch stage.
// Build with DELAY_SLOT_EN defined or not; the model follows the same macro.
module tb_instr_fetch;

    localparam int AB = 10;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, stall, flush, redirect;
    logic [31:0]   redirect_pc;
    logic [AB-1:0] rom_addr;
    logic          rom_sel;
    logic [31:0]   rom_dout;
    logic          id_valid;
    logic [31:0]   id_pc, id_instr, id_pc_plus4, pc, fetch_cnt;

    logic [31:0]   rom [0:(1<<AB)-1];

    always #5 clk = ~clk;

    assign rom_dout = rom[rom_addr];

    instr_fetch #(.ADDR_BITS(AB), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_dout(rom_dout),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .pc(pc), .fetch_cnt(fetch_cnt)
    );

    // Reference model state
    logic [31:0] m_pc, m_id_pc, m_id_instr, m_id_p4, m_cnt;
    logic        m_valid;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        logic [31:0] word;
        logic        keep;
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_id_pc = 32'h0;
            m_id_instr = 32'h0; m_id_p4 = 32'h0; m_cnt = 32'h0;
        end else if (stall) begin
            if (flush) m_valid = 1'b0;
        end else begin
            word       = rom[m_pc[AB+1:2]];
            keep       = !flush && (!redirect || DS);
            m_id_pc    = m_pc;
            m_id_p4    = m_pc + 32'd4;
            m_valid    = keep;
            m_id_instr = keep ? word : 32'h0;
            if (keep) m_cnt = m_cnt + 32'd1;
            m_pc       = redirect ? (redirect_pc & 32'hFFFF_FFFC) : m_pc + 32'd4;
        end
    endtask

    task automatic check_regs();
        check("pc", pc, m_pc);
        check("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
        check("id_pc", id_pc, m_id_pc);
        check("id_instr", id_instr, m_id_instr);
        check("id_pc_plus4", id_pc_plus4, m_id_p4);
        check("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    // One cycle: check combinational outputs, clock, check registers.
    task automatic step();
        #1;
        check("rom_sel", {31'h0, rom_sel}, {31'h0, !stall && !rst});
        check("rom_addr", {{(32-AB){1'b0}}, rom_addr}, {{(32-AB){1'b0}}, m_pc[AB+1:2]});
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic set_in(input logic r, input logic s, input logic f,
                          input logic rd, input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    endtask

    logic [31:0] exp_words [0:3];

    initial begin
        for (int i = 0; i < (1 << AB); i++) rom[i] = $urandom;
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
        exp_words[0] = 32'h11; exp_words[1] = 32'h22;
        exp_words[2] = 32'h33; exp_words[3] = 32'h44;
        m_pc = 0; m_valid = 0; m_id_pc = 0; m_id_instr = 0; m_id_p4 = 0; m_cnt = 0;

        // Reset state and first four fetches
        set_in(1, 0, 0, 0, 0);
        #1;
        check("rom_sel_in_rst", {31'h0, rom_sel}, 32'h0);
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'h0, id_valid}, 32'h0);
        check("rst_cnt", fetch_cnt, 32'h0);
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("seq_id_pc", id_pc, 32'(4 * i));
            check("seq_id_instr", id_instr, exp_words[i]);
            check("seq_valid", {31'h0, id_valid}, 32'h1);
        end
        check("seq_cnt4", fetch_cnt, 32'd4);

        // Stall for three cycles while pc == 8
        set_in(1, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0); step(); step();
        check("pre_stall_pc", pc, 32'h8);
        set_in(0, 1, 0, 1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_rom_sel", {31'h0, rom_sel}, 32'h0);
            step();
            check("stall_pc", pc, 32'h8);
            check("stall_id_pc", id_pc, 32'h4);
            check("stall_cnt", fetch_cnt, 32'd2);
        end
        set_in(0, 0, 0, 0, 0); step();
        check("resume_id_pc", id_pc, 32'h8);
        check("resume_instr", id_instr, 32'h33);

        // Redirect with misaligned target while pc == 4
        set_in(1, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 32'h0000_0043); step();
        check("redir_pc", pc, 32'h40);
        check("redir_id_pc", id_pc, 32'h4);
        check("redir_valid", {31'h0, id_valid}, {31'h0, DS});
        check("redir_instr", id_instr, DS ? 32'h22 : 32'h0);

        // Flush under stall
        set_in(0, 1, 1, 0, 0); step();
        check("fl_valid", {31'h0, id_valid}, 32'h0);
        check("fl_id_pc", id_pc, 32'h4);
        check("fl_pc", pc, 32'h40);

        // Reset overrides redirect and stall with fetch_cnt == 7
        set_in(1, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step();
        check("cnt7", fetch_cnt, 32'd7);
        set_in(1, 1, 0, 1, 32'h0000_0100); step();
        check("rst_ovr_pc", pc, 32'h0);
        check("rst_ovr_cnt", fetch_cnt, 32'h0);
        check("rst_ovr_valid", {31'h0, id_valid}, 32'h0);

        // PC wrap at top of address space
        set_in(0, 0, 0, 1, 32'hFFFF_FFFE); step();
        set_in(0, 0, 0, 0, 0); step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_p4", id_pc_plus4, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                   ($urandom_range(7) == 0), ($urandom_range(5) == 0), $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
